// File: rtl/my_sync_fifo_if.sv
// Handshake bundle between my_sync_fifo and its producer/consumer.
// The master side drives write/read requests; the slave side is the FIFO.
interface my_sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CW         = 5
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic                  overflow;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  almost_empty;
  logic                  underflow;
  logic [CW-1:0]         count;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, almost_full, overflow,
    input  rd_data, rd_valid, empty, almost_empty, underflow, count
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, almost_full, overflow,
    output rd_data, rd_valid, empty, almost_empty, underflow, count
  );
endinterface

// File: rtl/my_sync_fifo.sv
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, overflow/underflow error pulses and a
// selectable standard (latency-1) or first-word-fall-through read port.
module my_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AE_THRESH  = 2,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter bit FWFT       = 1'b0,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  my_sync_fifo_if.slave fifo_s
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > FIFO_DEPTH) begin : g_bad_thresh
    $error("my_sync_fifo: need 0 <= AE_THRESH < AF_THRESH <= FIFO_DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  af_q, af_d;
  logic                  empty_q, empty_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  acc_wr, acc_rd;

  // Next-state: accept decisions, pointer wrap, occupancy and flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    acc_wr   = fifo_s.wr_en && !full_q;
    acc_rd   = fifo_s.rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (acc_wr) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
    if (acc_rd) rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
    count_d  = count_q + CW'(acc_wr) - CW'(acc_rd);
    full_d   = (count_d == DEPTH_C);
    af_d     = (count_d >= AF_C);
    empty_d  = (count_d == '0);
    ae_d     = (count_d <= AE_C);
    ovf_d    = fifo_s.wr_en && full_q;
    udf_d    = fifo_s.rd_en && empty_q;
  end

  // Control state: pointers, count, flags and error pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      empty_q  <= 1'b1;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      af_q     <= af_d;
      empty_q  <= empty_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array: written on accepted writes only.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; the pointers and count define
    // which entries are valid, so stale contents are never observed.
    if (!reset && acc_wr) mem_q[wr_ptr_q] <= fifo_s.wr_data;
  end

  if (FWFT == 1'b0) begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Registered read port: word appears one edge after its accepted rd_en.
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= acc_rd;
        if (acc_rd) rd_data_q <= mem_q[rd_ptr_q];
      end
    end

    assign fifo_s.rd_data  = rd_data_q;
    assign fifo_s.rd_valid = rd_valid_q;
  end else begin : g_fwft
    assign fifo_s.rd_data  = mem_q[rd_ptr_q];
    assign fifo_s.rd_valid = !empty_q;
  end

  assign fifo_s.full         = full_q;
  assign fifo_s.almost_full  = af_q;
  assign fifo_s.overflow     = ovf_q;
  assign fifo_s.empty        = empty_q;
  assign fifo_s.almost_empty = ae_q;
  assign fifo_s.underflow    = udf_q;
  assign fifo_s.count        = count_q;

endmodule

// File: tb/tb_my_sync_fifo.sv
// Bench for my_sync_fifo: one standard-read and one FWFT instance fed the same
// traffic, a queue-based reference model compared every cycle, plus directed
// scenarios with literal expectations.
module tb_my_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AE    = 2;
  localparam int AF    = DEPTH - 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  my_sync_fifo_if #(.DATA_WIDTH(DW), .CW(CW)) if0 ();
  my_sync_fifo_if #(.DATA_WIDTH(DW), .CW(CW)) if1 ();

  assign if0.wr_en   = wr_en;
  assign if0.wr_data = wr_data;
  assign if0.rd_en   = rd_en;
  assign if1.wr_en   = wr_en;
  assign if1.wr_data = wr_data;
  assign if1.rd_en   = rd_en;

  my_sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AE_THRESH(AE),
                 .AF_THRESH(AF), .FWFT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .fifo_s(if0.slave));

  my_sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AE_THRESH(AE),
                 .AF_THRESH(AF), .FWFT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .fifo_s(if1.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the standard-mode read register.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_data0;
  logic          m_valid0;
  logic          m_ovf, m_udf;
  logic          live = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_data0  = '0;
      m_valid0 = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
      live     = 1'b1;
    end else begin
      m_ovf = wr_en && (mq.size() == DEPTH);
      m_udf = rd_en && (mq.size() == 0);
      if (rd_en && mq.size() != 0) begin
        m_data0  = mq.pop_front();
        m_valid0 = 1'b1;
      end else begin
        m_valid0 = 1'b0;
      end
      if (wr_en && !m_ovf) mq.push_back(wr_data);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (live) begin
      check("cmp_count",  32'(if0.count),      32'(mq.size()));
      check("cmp_full",   32'(if0.full),       32'(mq.size() == DEPTH));
      check("cmp_afull",  32'(if0.almost_full), 32'(mq.size() >= AF));
      check("cmp_empty",  32'(if0.empty),      32'(mq.size() == 0));
      check("cmp_aempty", 32'(if0.almost_empty), 32'(mq.size() <= AE));
      check("cmp_ovf",    32'(if0.overflow),   32'(m_ovf));
      check("cmp_udf",    32'(if0.underflow),  32'(m_udf));
      check("cmp_valid0", 32'(if0.rd_valid),   32'(m_valid0));
      check("cmp_data0",  32'(if0.rd_data),    32'(m_data0));
      check("cmp_count1", 32'(if1.count),      32'(mq.size()));
      check("cmp_ovf1",   32'(if1.overflow),   32'(m_ovf));
      check("cmp_udf1",   32'(if1.underflow),  32'(m_udf));
      check("cmp_valid1", 32'(if1.rd_valid),   32'(mq.size() != 0));
      if (mq.size() != 0) check("cmp_data1", 32'(if1.rd_data), 32'(mq[0]));
    end
  end

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    reset = 1'b0;
    check("rst_count",  32'(if0.count), 0);
    check("rst_empty",  32'(if0.empty), 1);
    check("rst_aempty", 32'(if0.almost_empty), 1);
    check("rst_full",   32'(if0.full), 0);
    check("rst_afull",  32'(if0.almost_full), 0);
    check("rst_valid",  32'(if0.rd_valid), 0);
    check("rst_data",   32'(if0.rd_data), 0);
    check("rst_errs",   32'({if0.overflow, if0.underflow}), 0);

    // Fill 16 words, then one rejected write.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0);
      if (i == 12) check("af_before_14", 32'(if0.almost_full), 0);
      if (i == 13) begin
        check("af_at_14",    32'(if0.almost_full), 1);
        check("count_at_14", 32'(if0.count), 14);
      end
    end
    check("full_at_16",  32'(if0.full), 1);
    check("count_at_16", 32'(if0.count), 16);
    step(1'b1, 8'h55, 1'b0);
    check("ovf_pulse",   32'(if0.overflow), 1);
    check("ovf_count",   32'(if0.count), 16);
    step(1'b0, '0, 1'b0);
    check("ovf_cleared", 32'(if0.overflow), 0);

    // Drain in order, then one rejected read.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      check("rd_valid", 32'(if0.rd_valid), 1);
      check("rd_data",  32'(if0.rd_data), 32'(i));
    end
    check("empty_after_drain", 32'(if0.empty), 1);
    step(1'b0, '0, 1'b1);
    check("udf_pulse",  32'(if0.underflow), 1);
    check("udf_valid",  32'(if0.rd_valid), 0);
    check("udf_hold",   32'(if0.rd_data), 32'h0F);

    // Three write-10/read-10 rounds crossing the pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 10; k++) step(1'b1, DW'(8'h20 + r * 16 + k), 1'b0);
      check("wrap_count10", 32'(if0.count), 10);
      for (int k = 0; k < 10; k++) begin
        step(1'b0, '0, 1'b1);
        check("wrap_data", 32'(if0.rd_data), 32'(8'h20 + r * 16 + k));
      end
      check("wrap_count0", 32'(if0.count), 0);
    end

    // Simultaneous read+write at mid, empty and full occupancy.
    for (int k = 0; k < 5; k++) step(1'b1, DW'(8'h50 + k), 1'b0);
    step(1'b1, 8'h60, 1'b1);
    check("sim_mid_count", 32'(if0.count), 5);
    check("sim_mid_data",  32'(if0.rd_data), 32'h50);
    for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1);
    check("sim_drained", 32'(if0.empty), 1);
    step(1'b1, 8'h77, 1'b1);
    check("sim_empty_count", 32'(if0.count), 1);
    check("sim_empty_udf",   32'(if0.underflow), 1);
    check("sim_empty_valid", 32'(if0.rd_valid), 0);
    for (int k = 0; k < DEPTH - 1; k++) step(1'b1, DW'(8'h80 + k), 1'b0);
    check("sim_filled", 32'(if0.full), 1);
    step(1'b1, 8'h88, 1'b1);
    check("sim_full_count", 32'(if0.count), 15);
    check("sim_full_ovf",   32'(if0.overflow), 1);
    check("sim_full_data",  32'(if0.rd_data), 32'h77);
    for (int k = 0; k < DEPTH - 1; k++) step(1'b0, '0, 1'b1);
    check("sim_final_empty", 32'(if0.empty), 1);

    // FWFT: a single write is shown without any rd_en.
    step(1'b1, 8'hA5, 1'b0);
    check("fwft_empty", 32'(if1.empty), 0);
    check("fwft_valid", 32'(if1.rd_valid), 1);
    check("fwft_data",  32'(if1.rd_data), 32'hA5);
    step(1'b0, '0, 1'b0);
    check("fwft_hold",  32'(if1.rd_data), 32'hA5);
    step(1'b0, '0, 1'b1);
    check("fwft_pop_empty", 32'(if1.empty), 1);
    check("fwft_pop_valid", 32'(if1.rd_valid), 0);

    // Reset mid-operation with both requests asserted.
    for (int k = 0; k < 7; k++) step(1'b1, DW'(8'h30 + k), 1'b0);
    check("pre_rst_count", 32'(if0.count), 7);
    reset = 1'b1;
    step(1'b1, 8'h99, 1'b1);
    reset = 1'b0;
    check("mrst_count",  32'(if0.count), 0);
    check("mrst_empty",  32'(if0.empty), 1);
    check("mrst_valid0", 32'(if0.rd_valid), 0);
    check("mrst_valid1", 32'(if1.rd_valid), 0);
    check("mrst_errs",   32'({if0.overflow, if0.underflow}), 0);
    step(1'b1, 8'h42, 1'b0);
    step(1'b0, '0, 1'b1);
    check("post_rst_data", 32'(if0.rd_data), 32'h42);
    step(1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
